arm_banked_regfile: RTL

- Parametrised successor to the single-bank ARMv4 register file.
- Adds ARM processor-mode banking of R8–R14 (FIQ / IRQ / SVC / ABT / UND), N read ports, two write ports (result + base writeback) and write-to-read bypass.
- Adds a per-physical-register busy scoreboard that raises a hazard for the issue stage.
- Sits between decode/issue and execute; R15 is supplied by the fetch unit.

---
 rtl/arm_rf_pkg.sv | 53 +++++
 rtl/arm_rf_map.sv | 36 +++
 rtl/arm_banked_regfile.sv | 136 +++++++++++++
 3 files changed

// File: rtl/arm_rf_pkg.sv
// Shared types and physical-register layout for the banked ARM register file.
package arm_rf_pkg;

  // Architectural CPSR[4:0] mode encodings.
  typedef enum logic [4:0] {
    MODE_USR = 5'b10000,
    MODE_FIQ = 5'b10001,
    MODE_IRQ = 5'b10010,
    MODE_SVC = 5'b10011,
    MODE_ABT = 5'b10111,
    MODE_UND = 5'b11011,
    MODE_SYS = 5'b11111
  } mode_e;

  // Register banks; the encoding doubles as the R13/R14 pair index.
  typedef enum logic [2:0] {
    BANK_USR = 3'd0,
    BANK_FIQ = 3'd1,
    BANK_IRQ = 3'd2,
    BANK_SVC = 3'd3,
    BANK_ABT = 3'd4,
    BANK_UND = 3'd5
  } bank_e;

  localparam int NUM_PHYS = 31;
  localparam int PHYS_W   = 5;

  // Physical layout: R0-R7 shared, user R8-R12, FIQ R8-R12,
  // six R13/R14 pairs (bank*2 + {0:R13,1:R14}), one spare slot.
  localparam logic [PHYS_W-1:0] PHYS_USR_HI_BASE = 5'd8;
  localparam logic [PHYS_W-1:0] PHYS_FIQ_HI_BASE = 5'd13;
  localparam logic [PHYS_W-1:0] PHYS_SP_LR_BASE  = 5'd18;
  localparam logic [PHYS_W-1:0] PHYS_SPARE       = 5'd30;

  // Select the active bank; SYS and unknown encodings share the user bank.
  function automatic bank_e mode_to_bank(input logic [4:0] mode, input logic force_usr);
    bank_e bank;
    if (force_usr) begin
      bank = BANK_USR;
    end else begin
      case (mode)
        MODE_FIQ: bank = BANK_FIQ;
        MODE_IRQ: bank = BANK_IRQ;
        MODE_SVC: bank = BANK_SVC;
        MODE_ABT: bank = BANK_ABT;
        MODE_UND: bank = BANK_UND;
        default:  bank = BANK_USR;
      endcase
    end
    return bank;
  endfunction

endpackage

// File: rtl/arm_rf_map.sv
// Logical-to-physical register index translation for one access port.
module arm_rf_map
  import arm_rf_pkg::*;
(
  input  logic [3:0]        addr_i,
  input  logic [4:0]        mode_i,
  input  logic              force_usr_i,
  output logic [PHYS_W-1:0] phys_o,
  output logic              valid_o
);

  bank_e bank_s;

  // Translate the logical address through the active bank; R15 has no storage.
  always_comb begin
    bank_s  = mode_to_bank(mode_i, force_usr_i);
    phys_o  = 5'd0;
    valid_o = 1'b1;
    if (addr_i == 4'd15) begin
      valid_o = 1'b0;
      phys_o  = 5'd0;
    end else if ((addr_i == 4'd13) || (addr_i == 4'd14)) begin
      // addr bit 1 distinguishes R14 (1110) from R13 (1101)
      phys_o = PHYS_SP_LR_BASE + {1'b0, bank_s, addr_i[1]};
    end else if (addr_i >= 4'd8) begin
      if (bank_s == BANK_FIQ) begin
        phys_o = PHYS_FIQ_HI_BASE + {2'b00, addr_i[2:0]};
      end else begin
        phys_o = PHYS_USR_HI_BASE + {2'b00, addr_i[2:0]};
      end
    end else begin
      phys_o = {1'b0, addr_i};
    end
  end

endmodule

// File: rtl/arm_banked_regfile.sv
// Mode-banked ARM register file with two write ports, write-to-read bypass
// and a per-physical-register busy scoreboard for the issue stage.
module arm_banked_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_RD   = 3,
  parameter int NUM_PHYS = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               mode,
  input  logic                     force_usr,
  input  logic [NUM_RD*4-1:0]      ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic [DATA_W-1:0]        pc_in,
  input  logic                     we0,
  input  logic [3:0]               wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [3:0]               wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     iss_valid,
  input  logic [3:0]               iss_dst,
  input  logic [NUM_RD-1:0]        rd_used,
  input  logic                     flush,
  output logic                     hazard,
  output logic [NUM_PHYS-1:0]      busy
);
  import arm_rf_pkg::*;

  // The spare slot (highest index) has no storage and never reports busy.
  logic [DATA_W-1:0] regs_q [NUM_PHYS-1];
  logic [DATA_W-1:0] regs_d [NUM_PHYS-1];
  logic [NUM_PHYS-1:0] busy_q, busy_d;

  logic [PHYS_W-1:0] rphys_s [NUM_RD];
  logic              rvalid_s [NUM_RD];
  logic [PHYS_W-1:0] wphys0_s, wphys1_s, iphys_s;
  logic              wvalid0_s, wvalid1_s, ivalid_s;
  logic              wr0_s, wr1_s, iss_s;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rmap
    arm_rf_map u_rmap (
      .addr_i(ra[4*g +: 4]), .mode_i(mode), .force_usr_i(force_usr),
      .phys_o(rphys_s[g]), .valid_o(rvalid_s[g])
    );
  end

  arm_rf_map u_wmap0 (.addr_i(wa0), .mode_i(mode), .force_usr_i(force_usr),
                      .phys_o(wphys0_s), .valid_o(wvalid0_s));
  arm_rf_map u_wmap1 (.addr_i(wa1), .mode_i(mode), .force_usr_i(force_usr),
                      .phys_o(wphys1_s), .valid_o(wvalid1_s));
  arm_rf_map u_imap  (.addr_i(iss_dst), .mode_i(mode), .force_usr_i(force_usr),
                      .phys_o(iphys_s), .valid_o(ivalid_s));

  // Qualified write/issue strobes; R15 targets never reach storage.
  assign wr0_s = we0 & wvalid0_s;
  assign wr1_s = we1 & wvalid1_s;
  assign iss_s = iss_valid & ivalid_s;

  // Read muxing: R15 returns the PC, otherwise bypass port 0, then port 1, then storage.
  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (!rvalid_s[i]) begin
        rd[i*DATA_W +: DATA_W] = pc_in;
      end else if (wr0_s && (wphys0_s == rphys_s[i])) begin
        rd[i*DATA_W +: DATA_W] = wd0;
      end else if (wr1_s && (wphys1_s == rphys_s[i])) begin
        rd[i*DATA_W +: DATA_W] = wd1;
      end else begin
        rd[i*DATA_W +: DATA_W] = regs_q[rphys_s[i]];
      end
    end
  end

  // Stall when a live operand is busy and not being produced this very cycle.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_used[i] && rvalid_s[i] && busy_q[rphys_s[i]] &&
          !(wr0_s && (wphys0_s == rphys_s[i])) &&
          !(wr1_s && (wphys1_s == rphys_s[i]))) begin
        hazard = 1'b1;
      end else begin
        hazard = hazard;
      end
    end
  end

  // Next register contents: port 0 wins a same-register collision.
  always_comb begin
    for (int p = 0; p < NUM_PHYS-1; p++) begin
      if (wr0_s && (wphys0_s == PHYS_W'(p))) begin
        regs_d[p] = wd0;
      end else if (wr1_s && (wphys1_s == PHYS_W'(p))) begin
        regs_d[p] = wd1;
      end else begin
        regs_d[p] = regs_q[p];
      end
    end
  end

  // Next scoreboard: flush, then write-back clears, then issue set (set wins).
  always_comb begin
    busy_d = '0;
    for (int p = 0; p < NUM_PHYS-1; p++) begin
      if (iss_s && (iphys_s == PHYS_W'(p))) begin
        busy_d[p] = 1'b1;
      end else if ((wr0_s && (wphys0_s == PHYS_W'(p))) ||
                   (wr1_s && (wphys1_s == PHYS_W'(p)))) begin
        busy_d[p] = 1'b0;
      end else if (flush) begin
        busy_d[p] = 1'b0;
      end else begin
        busy_d[p] = busy_q[p];
      end
    end
    busy_d[PHYS_SPARE] = 1'b0;
  end

  // State registers with synchronous reset discarding same-cycle writes and issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int p = 0; p < NUM_PHYS-1; p++) begin
        regs_q[p] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      regs_q <= regs_d;
    end
  end

  assign busy = busy_q;

endmodule
